// File: rtl/sm3_cmprss_arb.sv
// Round-robin arbiter sharing one SM3 compression core between N_REQ
// message requesters. A grant covers one whole message, from the first beat
// until the core returns the digest. The digest is then registered and
// tagged with the owning requester's ID.
module sm3_cmprss_arb #(
  parameter int N_REQ = 2,
  parameter int ID_W  = 1,
  parameter int DW    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_vld_i,
  input  logic [N_REQ-1:0]    req_lst_i,
  input  logic [N_REQ*DW-1:0] req_wj_i,
  input  logic [N_REQ*DW-1:0] req_wjj_i,
  output logic [N_REQ-1:0]    req_ena_o,
  output logic [DW-1:0]       core_wj_o,
  output logic [DW-1:0]       core_wjj_o,
  output logic                core_lst_o,
  output logic                core_vld_o,
  input  logic                core_ena_i,
  input  logic [255:0]        core_res_i,
  input  logic                core_res_vld_i,
  output logic [255:0]        res_o,
  output logic [ID_W-1:0]     res_id_o,
  output logic                res_vld_o,
  output logic                busy_o,
  output logic                err_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_WAIT_RES
  } state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] grant_q, grant_d;
  logic [ID_W-1:0] res_id_q, res_id_d;
  logic [255:0]    res_q, res_d;
  logic            res_vld_q, res_vld_d;
  logic            err_q, err_d;

  logic [ID_W-1:0] pick;
  logic [ID_W-1:0] grant_inc;
  logic            beat_vld;
  logic            lst_xfer;
  logic            take_res;

  // Lane mux: the granted requester's beat goes straight to the core.
  assign core_wj_o  = req_wj_i[grant_q*DW +: DW];
  assign core_wjj_o = req_wjj_i[grant_q*DW +: DW];
  assign core_lst_o = req_lst_i[grant_q];
  assign beat_vld   = req_vld_i[grant_q];
  assign lst_xfer   = beat_vld & core_ena_i & core_lst_o;

  // Next round-robin start point: the lane after the one just served.
  assign grant_inc = (grant_q == ID_W'(N_REQ - 1)) ? '0 : grant_q + ID_W'(1);

  // A result is accepted in WAIT_RES, or together with the last beat in BUSY.
  assign take_res = core_res_vld_i &
                    ((state_q == ST_WAIT_RES) || ((state_q == ST_BUSY) && lst_xfer));

  assign res_o     = res_q;
  assign res_id_o  = res_id_q;
  assign res_vld_o = res_vld_q;
  assign err_o     = err_q;
  assign busy_o    = (state_q != ST_IDLE);

  // Round-robin search: first requesting lane at or above rr_ptr, wrapping.
  always_comb begin
    logic            found;
    logic [ID_W-1:0] cand;
    // NOTE: every combinationally assigned variable gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    pick  = rr_ptr_q;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = ID_W'((int'(rr_ptr_q) + i) % N_REQ);
      if (!found && req_vld_i[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Next-state and handshake logic for the IDLE/BUSY/WAIT_RES controller.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    res_d      = res_q;
    res_id_d   = res_id_q;
    res_vld_d  = 1'b0;
    err_d      = err_q;
    core_vld_o = 1'b0;
    req_ena_o  = '0;

    case (state_q)
      ST_IDLE: begin
        if (|req_vld_i) begin
          grant_d = pick;
          state_d = ST_BUSY;
        end
        if (core_res_vld_i) err_d = 1'b1;
      end
      ST_BUSY: begin
        core_vld_o         = beat_vld;
        req_ena_o[grant_q] = core_ena_i;
        if (lst_xfer) begin
          state_d = core_res_vld_i ? ST_IDLE : ST_WAIT_RES;
        end else if (core_res_vld_i) begin
          err_d = 1'b1;
        end
      end
      ST_WAIT_RES: begin
        if (core_res_vld_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (take_res) begin
      res_d     = core_res_i;
      res_id_d  = grant_q;
      res_vld_d = 1'b1;
      rr_ptr_d  = grant_inc;
    end
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      // NOTE: the digest register is reset too, because res_o is observable
      // and must read zero after reset rather than stale data.
      res_q     <= '0;
      res_id_q  <= '0;
      res_vld_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      res_q     <= res_d;
      res_id_q  <= res_id_d;
      res_vld_q <= res_vld_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_sm3_cmprss_arb.sv
// Directed bench for sm3_cmprss_arb with two requesters and 32-bit beats.
module tb_sm3_cmprss_arb;

  localparam int N  = 2;
  localparam int DW = 32;
  localparam logic [255:0] DIG_BASE =
    256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4b8e2a;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_vld_i = '0;
  logic [N-1:0]    req_lst_i = '0;
  logic [N*DW-1:0] req_wj_i = '0;
  logic [N*DW-1:0] req_wjj_i = '0;
  logic [N-1:0]    req_ena_o;
  logic [DW-1:0]   core_wj_o, core_wjj_o;
  logic            core_lst_o, core_vld_o;
  logic            core_ena_i = 1'b0;
  logic [255:0]    core_res_i = '0;
  logic            core_res_vld_i = 1'b0;
  logic [255:0]    res_o;
  logic [0:0]      res_id_o;
  logic            res_vld_o, busy_o, err_o;

  int checks = 0;
  int failures = 0;

  sm3_cmprss_arb #(.N_REQ(N), .ID_W(1), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld_i(req_vld_i), .req_lst_i(req_lst_i),
    .req_wj_i(req_wj_i), .req_wjj_i(req_wjj_i), .req_ena_o(req_ena_o),
    .core_wj_o(core_wj_o), .core_wjj_o(core_wjj_o), .core_lst_o(core_lst_o),
    .core_vld_o(core_vld_o), .core_ena_i(core_ena_i),
    .core_res_i(core_res_i), .core_res_vld_i(core_res_vld_i),
    .res_o(res_o), .res_id_o(res_id_o), .res_vld_o(res_vld_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // Beat payload: lane in [31:24], message index in [23:16], beat in [15:0].
  function automatic logic [31:0] mk(input int lane, input int msg, input int beat);
    return (32'(lane) << 24) | (32'(msg & 255) << 16) | 32'(beat & 16'hffff);
  endfunction

  function automatic logic [255:0] dig(input int lane, input int msg);
    return DIG_BASE ^ {248'd0, 4'(lane), 4'(msg)};
  endfunction

  task automatic idle_inputs();
    req_vld_i      = '0;
    req_lst_i      = '0;
    req_wj_i       = '0;
    req_wjj_i      = '0;
    core_ena_i     = 1'b0;
    core_res_vld_i = 1'b0;
    core_res_i     = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drives q0/q1 messages of 'beats' beats from lanes 0/1, models the core
  // (result 'lat' cycles after the last beat, 0 = same cycle), and checks the
  // handshake every cycle. Bit i of 'ids' is the lane expected to own message i.
  task automatic run_msgs(input int q0, input int q1, input int beats, input int lat,
                          input bit bp, input logic [3:0] ids);
    int quota[2], lmsg[2], lbeat[2], xfers[2];
    int cur, cyc, ph, wait_cnt, total, el, res_lane, res_msg;
    bit pend, in_wait, expect_busy;
    logic [1:0] exp_ena;
    logic       exp_cv;
    quota[0] = q0; quota[1] = q1;
    for (int k = 0; k < 2; k++) begin lmsg[k] = 0; lbeat[k] = 0; xfers[k] = 0; end
    cur = 0; cyc = 0; ph = 0; wait_cnt = 0; total = q0 + q1;
    res_lane = 0; res_msg = 0; pend = 0; in_wait = 0; expect_busy = 0;
    while (cur < total && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      for (int k = 0; k < 2; k++) begin
        req_vld_i[k]             = (lmsg[k] < quota[k]);
        req_lst_i[k]             = (lbeat[k] == beats - 1);
        req_wj_i[k*DW +: DW]     = mk(k, lmsg[k], lbeat[k]);
        req_wjj_i[k*DW +: DW]    = ~mk(k, lmsg[k], lbeat[k]);
      end
      core_ena_i = bp ? ((ph % 3) == 0) : 1'b1;
      ph++;
      core_res_vld_i = 1'b0;
      if (pend) begin
        wait_cnt--;
        if (wait_cnt == 0) begin
          core_res_vld_i = 1'b1;
          core_res_i     = dig(res_lane, res_msg);
          pend           = 0;
        end
      end
      #1;
      el = int'(ids[cur]);
      if (expect_busy) begin
        checks++;
        if (busy_o !== 1'b1) begin
          failures++;
          $display("FAIL back_to_back_grant: busy_o=%b expected 1", busy_o);
        end
        expect_busy = 0;
      end
      // Handshake: only the granted lane sees core_ena_i, and never in WAIT_RES.
      if (busy_o) begin
        exp_ena = (in_wait || !core_ena_i) ? 2'b00 : (2'b01 << el);
        exp_cv  = in_wait ? 1'b0 : req_vld_i[el];
      end else begin
        exp_ena = 2'b00;
        exp_cv  = 1'b0;
      end
      checks++;
      if (req_ena_o !== exp_ena || core_vld_o !== exp_cv) begin
        failures++;
        $display("FAIL handshake cyc=%0d: req_ena_o=%b core_vld_o=%b expected %b %b",
                 cyc, req_ena_o, core_vld_o, exp_ena, exp_cv);
      end
      // Beat forwarded this cycle: must be the granted lane's current beat.
      if (busy_o && !in_wait && req_vld_i[el] && core_ena_i) begin
        checks++;
        if (core_wj_o !== mk(el, lmsg[el], lbeat[el]) ||
            core_wjj_o !== ~mk(el, lmsg[el], lbeat[el]) ||
            core_lst_o !== (lbeat[el] == beats - 1)) begin
          failures++;
          $display("FAIL beat_data: wj=%h lst=%b expected wj=%h lst=%b",
                   core_wj_o, core_lst_o, mk(el, lmsg[el], lbeat[el]),
                   (lbeat[el] == beats - 1));
        end
        xfers[el]++;
        if (lbeat[el] == beats - 1) begin
          res_lane  = el;
          res_msg   = lmsg[el];
          lbeat[el] = 0;
          lmsg[el]++;
          in_wait   = 1;
          if (lat == 0) begin
            core_res_vld_i = 1'b1;
            core_res_i     = dig(res_lane, res_msg);
          end else begin
            pend     = 1;
            wait_cnt = lat;
          end
        end else begin
          lbeat[el]++;
        end
      end
      if (res_vld_o) begin
        checks++;
        if (res_id_o !== 1'(el) || res_o !== dig(res_lane, res_msg) || busy_o !== 1'b0) begin
          failures++;
          $display("FAIL result: id=%0d busy=%b res=%h expected id=%0d busy=0 res=%h",
                   res_id_o, busy_o, res_o, el, dig(res_lane, res_msg));
        end
        cur++;
        in_wait = 0;
        if (lmsg[0] < quota[0] || lmsg[1] < quota[1]) expect_busy = 1;
      end
    end
    checks++;
    if (cyc >= 4000) begin
      failures++;
      $display("FAIL timeout: results=%0d expected %0d", cur, total);
    end
    checks++;
    if (xfers[0] != q0 * beats || xfers[1] != q1 * beats || err_o !== 1'b0) begin
      failures++;
      $display("FAIL transfer_count: lane0=%0d lane1=%0d err=%b expected %0d %0d 0",
               xfers[0], xfers[1], err_o, q0 * beats, q1 * beats);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (res_o !== '0 || res_id_o !== 1'b0 || res_vld_o !== 1'b0 || busy_o !== 1'b0 ||
        err_o !== 1'b0 || req_ena_o !== 2'b00 || core_vld_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: res=%h id=%b vld=%b busy=%b err=%b ena=%b cvld=%b expected all 0",
               res_o, res_id_o, res_vld_o, busy_o, err_o, req_ena_o, core_vld_o);
    end
    do_reset();
    @(negedge clk);
    #1;
    checks++;
    if (busy_o !== 1'b0 || err_o !== 1'b0 || res_vld_o !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle: busy=%b err=%b vld=%b expected 0 0 0",
               busy_o, err_o, res_vld_o);
    end
  endtask

  task automatic test_single();
    do_reset();
    run_msgs(1, 0, 64, 5, 1'b0, 4'b0000);
  endtask

  task automatic test_contention();
    do_reset();
    run_msgs(2, 1, 8, 3, 1'b0, 4'b0010);
  endtask

  task automatic test_backpressure();
    do_reset();
    run_msgs(0, 1, 10, 2, 1'b1, 4'b0001);
  endtask

  task automatic test_simultaneous();
    do_reset();
    run_msgs(1, 0, 4, 0, 1'b0, 4'b0000);
    #1;
    checks++;
    if (res_vld_o !== 1'b0 || busy_o !== 1'b0 || err_o !== 1'b0) begin
      failures++;
      $display("FAIL simultaneous_after: vld=%b busy=%b err=%b expected 0 0 0",
               res_vld_o, busy_o, err_o);
    end
  endtask

  task automatic test_rr_pointer();
    do_reset();
    run_msgs(1, 0, 3, 1, 1'b0, 4'b0000);
    run_msgs(1, 0, 3, 1, 1'b0, 4'b0000);
    run_msgs(1, 1, 3, 1, 1'b0, 4'b0001);
  endtask

  task automatic test_spurious();
    do_reset();
    @(negedge clk);
    core_res_vld_i = 1'b1;
    core_res_i     = {8{32'hdeadbeef}};
    @(negedge clk);
    core_res_vld_i = 1'b0;
    #1;
    checks++;
    if (err_o !== 1'b1 || res_vld_o !== 1'b0 || res_o !== '0) begin
      failures++;
      $display("FAIL spurious_idle: err=%b vld=%b res=%h expected 1 0 0", err_o, res_vld_o, res_o);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (err_o !== 1'b1 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL err_sticky: err=%b busy=%b expected 1 0", err_o, busy_o);
    end
    do_reset();
    @(negedge clk);
    req_vld_i  = 2'b01;
    core_ena_i = 1'b0;
    @(negedge clk);
    core_res_vld_i = 1'b1;
    @(negedge clk);
    core_res_vld_i = 1'b0;
    #1;
    checks++;
    if (err_o !== 1'b1 || busy_o !== 1'b1 || res_vld_o !== 1'b0) begin
      failures++;
      $display("FAIL spurious_busy: err=%b busy=%b vld=%b expected 1 1 0", err_o, busy_o, res_vld_o);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    run_msgs(1, 0, 4, 1, 1'b0, 4'b0000);
    req_vld_i            = 2'b10;
    req_wj_i[DW +: DW]   = mk(1, 0, 0);
    core_ena_i           = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (busy_o !== 1'b1) begin
      failures++;
      $display("FAIL mid_setup_busy: busy=%b expected 1", busy_o);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (res_o !== '0 || res_id_o !== 1'b0 || res_vld_o !== 1'b0 || busy_o !== 1'b0 ||
        err_o !== 1'b0 || req_ena_o !== 2'b00 || core_vld_o !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_values: res=%h busy=%b ena=%b cvld=%b expected 0 0 0 0",
               res_o, busy_o, req_ena_o, core_vld_o);
    end
    @(negedge clk);
    rst_n                = 1'b1;
    req_vld_i            = 2'b11;
    req_wj_i[0 +: DW]    = mk(0, 0, 0);
    req_wj_i[DW +: DW]   = mk(1, 0, 0);
    core_ena_i           = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (req_ena_o !== 2'b01 || core_wj_o !== mk(0, 0, 0)) begin
      failures++;
      $display("FAIL first_grant_after_reset: ena=%b wj=%h expected 01 %h",
               req_ena_o, core_wj_o, mk(0, 0, 0));
    end
    idle_inputs();
    do_reset();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_simultaneous();
    test_rr_pointer();
    test_spurious();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sm3_cmprss_arb.md
Name: sm3_cmprss_arb

Overview:
- Shares one sm3_cmprss_core between N_REQ independent message requesters, at whole-message granularity.
- A grant is held from the first beat until the core returns the 256-bit digest. The digest is then returned tagged with the requester ID.
- Sits between the per-channel message-expansion front-ends and the single compression core.
- Fairness is round-robin.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- ID_W, 1, width of the requester ID; must satisfy 2^ID_W >= N_REQ.
- DW, 32, beat width of Wj/Wj' (32 or 64; matches the core's input width).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_vld_i  in  N_REQ  per-requester beat valid
- req_lst_i  in  N_REQ  per-requester last beat of the message
- req_wj_i  in  N_REQ*DW  flattened Wj; requester k occupies bits [k*DW +: DW]
- req_wjj_i  in  N_REQ*DW  flattened Wj', same packing as req_wj_i
- req_ena_o  out  N_REQ  per-requester beat accept
- core_wj_o  out  DW  Wj to core
- core_wjj_o  out  DW  Wj' to core
- core_lst_o  out  1  last beat to core
- core_vld_o  out  1  beat valid to core
- core_ena_i  in  1  core accept (expnd_inpt_ena_o)
- core_res_i  in  256  core digest
- core_res_vld_i  in  1  core digest valid
- res_o  out  256  registered digest
- res_id_o  out  ID_W  requester that owns res_o
- res_vld_o  out  1  one-cycle digest strobe
- busy_o  out  1  state != IDLE
- err_o  out  1  sticky protocol error

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, grant_id=0, res_o=0, res_id_o=0, res_vld_o=0, err_o=0. All req_ena_o=0, core_vld_o=0.
- Reset is asynchronous; asserting it mid-message abandons the message with no result. After reset the core must also be reset by the system.
- Transfer definition: a transfer occurs on core_vld_o & core_ena_i.
- State IDLE:
  - If any req_vld_i is set, register the first set bit searching upward from rr_ptr (wrapping) as grant_id, then go to BUSY.
  - No beat is forwarded in IDLE, so arbitration costs exactly 1 cycle.
- State BUSY:
  - core_wj_o, core_wjj_o and core_lst_o are combinational muxes of the granted lane.
  - core_vld_o = req_vld_i[grant_id].
  - req_ena_o[grant_id] = core_ena_i; all other lanes are 0.
  - A transfer with lst=1 goes to WAIT_RES.
  - The grant never changes mid-message, and other requesters' valids are ignored.
- State WAIT_RES:
  - core_vld_o=0; all req_ena_o=0.
  - On core_res_vld_i: latch res_o=core_res_i and res_id_o=grant_id, and pulse res_vld_o high the next cycle.
  - Then set rr_ptr = (grant_id+1) mod N_REQ and go to IDLE.
- Simultaneous last beat and result: if core_res_vld_i coincides with the lst transfer in BUSY, treat it as the WAIT_RES result. Latch it and go directly to IDLE.
- core_res_vld_i in IDLE, or in BUSY without a concurrent lst transfer: ignore the data and set err_o. err_o is cleared only by reset.
- Back-to-back operation: the next grant can be registered in the cycle res_vld_o is high. Minimum gap between the last beat of one message and the first beat of the next = core result latency + 2 cycles.
- Single requester: rr_ptr still advances. The same lane is re-granted whenever it is the only lane requesting.
- rr_ptr wraps from N_REQ-1 to 0.

Test Plan:
- Single message, lane 0: 64 beats, core_ena_i=1, core returns digest 0x66c7f0f4…8e2a after 5 cycles in WAIT_RES -> exactly 64 transfers; res_vld_o one-cycle pulse with res_id_o=0 and res_o equal to the digest; busy_o falls the same cycle.
- Contention, N_REQ=2: both lanes valid from cycle 0 -> lane 0 served first; its result has res_id_o=0. Lane 1 is then granted, and req_ena_o[1] stays 0 for the whole of lane 0's message. Third round goes to lane 0.
- Backpressure: core_ena_i toggles 1,0,0,1… -> req_ena_o[grant] mirrors core_ena_i. Beat order and count are preserved, with no duplicated or dropped beats.
- Simultaneous last beat and result -> single res_vld_o pulse; next state IDLE; err_o stays 0.
- Spurious core_res_vld_i while in IDLE -> err_o=1 and held; res_vld_o stays 0; res_o unchanged.
- rst_n asserted mid-BUSY -> all outputs reach their reset values immediately. After release, the first grant goes to lane 0.
